lzc_norm_pipe: RTL

- Parametrised, pipelined leading-zero-count and normalisation unit; successor to the fixed 48-bit combinational LZ counter feeding the floating-point adder.
- Computes the leading-zero count of a WIDTH-bit operand and optionally left-normalises it.
- Two-stage pipeline with valid/ready handshake, so it serves both the scalar FP adder and the scalar population/leading-zero functional unit without combinational paths into the consumer.

---
 rtl/lzc_norm_pipe.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/lzc_norm_pipe.sv
// Two-stage pipelined leading-zero count / popcount / left-normalise unit with a valid/ready handshake.
// Define LZC_NORM_POPCNT_EN to build the popcount mode (01); without it, mode 01 decodes as LZC.
module lzc_norm_pipe #(
    parameter int WIDTH = 48,
    parameter int GROUP = 8,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic [1:0]       i_mode,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [CNT_W-1:0] o_count,
    output logic [WIDTH-1:0] o_data,
    output logic             o_zero
);

    localparam int NG = WIDTH / GROUP;
    localparam int GW = $clog2(GROUP + 1);

    generate
        if ((WIDTH % GROUP) != 0) begin : g_bad_width
            $error("lzc_norm_pipe: WIDTH must be a multiple of GROUP");
        end
        if (GROUP > 16 || (GROUP & (GROUP - 1)) != 0) begin : g_bad_group
            $error("lzc_norm_pipe: GROUP must be a power of 2, at most 16");
        end
        if ((2 ** CNT_W) <= WIDTH) begin : g_bad_cnt
            $error("lzc_norm_pipe: CNT_W too narrow to hold WIDTH");
        end
    endgenerate

    // Group NG-1 holds the operand MSBs; group 0 holds the LSBs.
    logic [NG-1:0][GROUP-1:0] in_grp;
    logic [NG-1:0]            grp_nz;
    logic [NG-1:0][GW-1:0]    grp_lz;

    logic                     s1_valid;
    logic [NG-1:0]            s1_nz;
    logic [NG-1:0][GW-1:0]    s1_lz;
    logic [WIDTH-1:0]         s1_data;
    logic [1:0]               s1_mode;

    logic                     s2_load;
    logic [CNT_W-1:0]         lz_count;
    logic [CNT_W-1:0]         result_count;
    logic [WIDTH-1:0]         result_data;
    logic                     all_zero;

    assign in_grp = i_data;

    // Stage 2 can take new data when empty or when its result is leaving this cycle.
    assign s2_load = !o_valid || o_ready;
    assign i_ready = !s1_valid || s2_load;

    // Per-group priority encode; the highest set bit wins because it is assigned last.
    always_comb begin
        for (int g = 0; g < NG; g++) begin
            grp_nz[g] = |in_grp[g];
            grp_lz[g] = '0;
            for (int b = 0; b < GROUP; b++) begin
                if (in_grp[g][b]) begin
                    grp_lz[g] = GW'(GROUP - 1 - b);
                end
            end
        end
    end

`ifdef LZC_NORM_POPCNT_EN
    logic [NG-1:0][GW-1:0] grp_pop;
    logic [NG-1:0][GW-1:0] s1_pop;
    logic [CNT_W-1:0]      pop_count;

    always_comb begin
        for (int g = 0; g < NG; g++) begin
            grp_pop[g] = '0;
            for (int b = 0; b < GROUP; b++) begin
                grp_pop[g] = grp_pop[g] + GW'(in_grp[g][b]);
            end
        end
    end

    always_comb begin
        pop_count = '0;
        for (int g = 0; g < NG; g++) begin
            pop_count = pop_count + CNT_W'(s1_pop[g]);
        end
    end

    always_ff @(posedge clk) begin
        if (i_valid && i_ready) begin
            s1_pop <= grp_pop;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (i_ready) begin
            s1_valid <= i_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (i_valid && i_ready) begin
            s1_nz   <= grp_nz;
            s1_lz   <= grp_lz;
            s1_data <= i_data;
            s1_mode <= i_mode;
        end
    end

    // Scan LSB group upward so the most significant nonzero group is assigned last.
    always_comb begin
        lz_count = CNT_W'(WIDTH);
        for (int g = 0; g < NG; g++) begin
            if (s1_nz[g]) begin
                lz_count = CNT_W'((NG - 1 - g) * GROUP) + CNT_W'(s1_lz[g]);
            end
        end
    end

    assign all_zero = ~|s1_nz;

    always_comb begin
        result_count = lz_count;
        result_data  = s1_data;
`ifdef LZC_NORM_POPCNT_EN
        if (s1_mode == 2'b01) begin
            result_count = pop_count;
        end
`endif
        if (s1_mode == 2'b10) begin
            result_data = s1_data << lz_count;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_count <= '0;
            o_data  <= '0;
            o_zero  <= 1'b0;
        end else if (s2_load) begin
            o_valid <= s1_valid;
            if (s1_valid) begin
                o_count <= result_count;
                o_data  <= result_data;
                o_zero  <= all_zero;
            end
        end
    end

endmodule
